// File: rtl/l2_block_adapter_if.sv
// Block-request bus and word-wide L2 port of the L2 block adapter.
// slave = adapter view; master = requester / L2 memory view.
interface l2_block_adapter_if #(
    parameter int unsigned WORD_W           = 32,
    parameter int unsigned BLOCK_SIZE_WORDS = 2,
    parameter int unsigned ADDR_W           = 32
);
    logic                               blk_req;
    logic                               blk_wen;
    logic [ADDR_W-1:0]                  blk_addr;
    logic [BLOCK_SIZE_WORDS*WORD_W-1:0] blk_wdata;
    logic                               blk_done;
    logic                               blk_error;
    logic [BLOCK_SIZE_WORDS*WORD_W-1:0] blk_rdata;
    logic                               l2_ren;
    logic                               l2_wen;
    logic [ADDR_W-1:0]                  l2_addr;
    logic [WORD_W-1:0]                  l2_store;
    logic [WORD_W-1:0]                  l2_load;
    logic                               l2_ready;

    modport slave (
        input  blk_req, blk_wen, blk_addr, blk_wdata, l2_load, l2_ready,
        output blk_done, blk_error, blk_rdata, l2_ren, l2_wen, l2_addr, l2_store
    );

    modport master (
        output blk_req, blk_wen, blk_addr, blk_wdata, l2_load, l2_ready,
        input  blk_done, blk_error, blk_rdata, l2_ren, l2_wen, l2_addr, l2_store
    );
endinterface

// File: rtl/l2_block_adapter.sv
// Serializes block fills/writebacks into single-word L2 accesses and reassembles fills.
// Optional per-word stall timeout: define L2_ADAPTER_TIMEOUT_EN.
module l2_block_adapter #(
    parameter int unsigned WORD_W           = 32,
    parameter int unsigned BLOCK_SIZE_WORDS = 2,
    parameter int unsigned ADDR_W           = 32,
    parameter int unsigned TIMEOUT_CYCLES   = 25
) (
    input  logic              CLK,
    input  logic              nRST,
    l2_block_adapter_if.slave bus
);
    localparam int unsigned BlkW      = BLOCK_SIZE_WORDS * WORD_W;
    localparam int unsigned WordBytes = WORD_W / 8;
    localparam int unsigned IdxW      = (BLOCK_SIZE_WORDS > 1) ? $clog2(BLOCK_SIZE_WORDS) : 1;
    localparam logic [IdxW-1:0]   LastIdx = IdxW'(BLOCK_SIZE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OffMask = ADDR_W'((BLOCK_SIZE_WORDS * WordBytes) - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

    state_t              r_state;
    logic [IdxW-1:0]     r_idx;
    logic                r_wen;
    logic [BlkW-1:0]     r_wdata;
    logic [BlkW-1:0]     r_rdata;
    logic                r_done;
    logic                r_ren;
    logic                r_l2wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_store;

    logic [ADDR_W-1:0]   w_base;
    logic [IdxW-1:0]     w_idx_nxt;

    assign w_base    = bus.blk_addr & ~OffMask;
    assign w_idx_nxt = r_idx + 1'b1;

`ifdef L2_ADAPTER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] r_tmo;
    logic            r_error;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_ren   <= 1'b0;
            r_l2wen <= 1'b0;
            r_addr  <= '0;
            r_store <= '0;
`ifdef L2_ADAPTER_TIMEOUT_EN
            r_tmo   <= '0;
            r_error <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef L2_ADAPTER_TIMEOUT_EN
            r_error <= 1'b0;
`endif
            unique case (r_state)
                StIdle: begin
                    if (bus.blk_req) begin
                        r_state <= StAccess;
                        r_idx   <= '0;
                        r_wen   <= bus.blk_wen;
                        r_wdata <= bus.blk_wdata;
                        r_ren   <= ~bus.blk_wen;
                        r_l2wen <= bus.blk_wen;
                        r_addr  <= w_base;
                        r_store <= bus.blk_wdata[WORD_W-1:0];
`ifdef L2_ADAPTER_TIMEOUT_EN
                        r_tmo   <= '0;
`endif
                    end
                end
                StAccess: begin
                    if (bus.l2_ready) begin
                        if (!r_wen) begin
                            r_rdata[int'(r_idx)*WORD_W +: WORD_W] <= bus.l2_load;
                        end
`ifdef L2_ADAPTER_TIMEOUT_EN
                        r_tmo <= '0;
`endif
                        if (r_idx == LastIdx) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_ren   <= 1'b0;
                            r_l2wen <= 1'b0;
                            r_addr  <= '0;
                            r_store <= '0;
                        end else begin
                            // Address advances incrementally; wraps modulo 2^ADDR_W
                            r_idx   <= w_idx_nxt;
                            r_addr  <= r_addr + ADDR_W'(WordBytes);
                            r_store <= r_wdata[int'(w_idx_nxt)*WORD_W +: WORD_W];
                        end
                    end
`ifdef L2_ADAPTER_TIMEOUT_EN
                    else if (r_tmo == TmoW'(TIMEOUT_CYCLES)) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_ren   <= 1'b0;
                        r_l2wen <= 1'b0;
                        r_addr  <= '0;
                        r_store <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.blk_done  = r_done;
    assign bus.blk_rdata = r_rdata;
    assign bus.l2_ren    = r_ren;
    assign bus.l2_wen    = r_l2wen;
    assign bus.l2_addr   = r_addr;
    assign bus.l2_store  = r_store;
`ifdef L2_ADAPTER_TIMEOUT_EN
    assign bus.blk_error = r_error;
`else
    assign bus.blk_error = 1'b0;
`endif

endmodule

// File: tb/tb_l2_block_adapter.sv
// Randomized self-checking bench for l2_block_adapter (default parameters).
// Honours L2_ADAPTER_TIMEOUT_EN when the stall-timeout scenario runs.
module tb_l2_block_adapter;
    localparam int unsigned WordW     = 32;
    localparam int unsigned Blk       = 2;
    localparam int unsigned AddrW     = 32;
    localparam int unsigned Tmo       = 25;
    localparam int unsigned BlkW      = WordW * Blk;
    localparam int unsigned WordBytes = WordW / 8;

    logic clk = 1'b0;
    logic nrst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [BlkW-1:0]  exp_rdata;
    logic [WordW-1:0] load_q [Blk];
    int               stall_q [Blk];

    l2_block_adapter_if #(.WORD_W(WordW), .BLOCK_SIZE_WORDS(Blk), .ADDR_W(AddrW)) bus ();

    l2_block_adapter #(
        .WORD_W          (WordW),
        .BLOCK_SIZE_WORDS(Blk),
        .ADDR_W          (AddrW),
        .TIMEOUT_CYCLES  (Tmo)
    ) dut (
        .CLK (clk),
        .nRST(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AddrW-1:0] blk_base(input logic [AddrW-1:0] a);
        return a & ~AddrW'(Blk * WordBytes - 1);
    endfunction

    // Starts in IDLE at a negedge; returns at the negedge of the IDLE cycle after blk_done.
    task automatic txn(input logic [AddrW-1:0] addr, input logic wen,
                       input logic [BlkW-1:0] wdata, input bit keep);
        logic [AddrW-1:0] base;
        logic [BlkW-1:0]  fill;
        base = blk_base(addr);
        fill = exp_rdata;
        bus.blk_req   = 1'b1;
        bus.blk_wen   = wen;
        bus.blk_addr  = addr;
        bus.blk_wdata = wdata;
        bus.l2_ready  = 1'b0;
        @(negedge clk);
        // Live inputs must be ignored once latched
        bus.blk_addr  = $urandom;
        bus.blk_wdata = {$urandom, $urandom};
        for (int i = 0; i < int'(Blk); i++) begin
            for (int k = 0; k <= stall_q[i]; k++) begin
                check("l2_ren", bus.l2_ren, !wen);
                check("l2_wen", bus.l2_wen, wen);
                check("l2_addr", bus.l2_addr, base + AddrW'(i * WordBytes));
                if (wen) check("l2_store", bus.l2_store, wdata[i*WordW +: WordW]);
                check("early_done", bus.blk_done, 0);
                bus.l2_ready = (k == stall_q[i]);
                bus.l2_load  = (k == stall_q[i]) ? load_q[i] : WordW'($urandom);
                @(negedge clk);
            end
            if (!wen) fill[i*WordW +: WordW] = load_q[i];
        end
        exp_rdata = fill;
        check("done", bus.blk_done, 1);
        check("error", bus.blk_error, 0);
        check("rdata", bus.blk_rdata, exp_rdata);
        check("done_strobes", {bus.l2_ren, bus.l2_wen}, 0);
        bus.l2_ready = 1'($urandom);
        if (!keep) bus.blk_req = 1'b0;
        @(negedge clk);
        check("idle_done", bus.blk_done, 0);
        check("idle_strobes", {bus.l2_ren, bus.l2_wen}, 0);
        check("idle_rdata", bus.blk_rdata, exp_rdata);
        bus.l2_ready = 1'b0;
    endtask

    task automatic rand_plan(input int max_stall);
        for (int i = 0; i < int'(Blk); i++) begin
            stall_q[i] = $urandom_range(0, max_stall);
            load_q[i]  = $urandom;
        end
    endtask

    initial begin
        int  n_done;
        int  done_at;
        int  err_pulses;
        bit  err_at_done;
        bit  got_done;
        logic [AddrW-1:0] a2;

        nrst          = 1'b0;
        bus.blk_req   = 1'b0;
        bus.blk_wen   = 1'b0;
        bus.blk_addr  = '0;
        bus.blk_wdata = '0;
        bus.l2_load   = '0;
        bus.l2_ready  = 1'b0;
        exp_rdata     = '0;
        repeat (2) @(negedge clk);
        check("rst_done", bus.blk_done, 0);
        check("rst_error", bus.blk_error, 0);
        check("rst_rdata", bus.blk_rdata, 0);
        check("rst_ren", bus.l2_ren, 0);
        check("rst_wen", bus.l2_wen, 0);
        check("rst_addr", bus.l2_addr, 0);
        check("rst_store", bus.l2_store, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Plain fill, no stalls
        stall_q[0] = 0; stall_q[1] = 0;
        load_q[0] = 32'hAAAA_0001; load_q[1] = 32'hAAAA_0002;
        txn(32'h0000_1234, 1'b0, {$urandom, $urandom}, 1'b0);
        check("tp_fill_rdata", bus.blk_rdata, 64'hAAAA_0002_AAAA_0001);

        // Writeback with three stall cycles on word 0
        stall_q[0] = 3; stall_q[1] = 0;
        txn(32'h8000_0000, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);

        // Top-of-memory block
        rand_plan(0);
        txn(32'hFFFF_FFFC, 1'b0, {$urandom, $urandom}, 1'b0);

        for (int t = 0; t < 40; t++) begin
            rand_plan(4);
            txn($urandom, 1'($urandom), {$urandom, $urandom}, 1'b0);
        end

        // Request held through done: next strobe two cycles after done
        rand_plan(1);
        txn($urandom, 1'b1, {$urandom, $urandom}, 1'b1);
        a2 = bus.blk_addr;
        @(negedge clk);
        check("b2b_wen", bus.l2_wen, 1);
        check("b2b_addr", bus.l2_addr, blk_base(a2));
        bus.l2_ready = 1'b1;
        got_done = 1'b0;
        for (int c = 0; c < 10 && !got_done; c++) begin
            @(negedge clk);
            got_done = bus.blk_done;
        end
        check("b2b_done", got_done, 1);
        check("b2b_rdata", bus.blk_rdata, exp_rdata);
        bus.blk_req  = 1'b0;
        bus.l2_ready = 1'b0;
        @(negedge clk);

        // Reset in the middle of a fill
        bus.blk_req  = 1'b1;
        bus.blk_wen  = 1'b0;
        bus.blk_addr = $urandom;
        @(negedge clk);
        bus.l2_ready = 1'b1;
        bus.l2_load  = $urandom;
        @(negedge clk);
        check("mid_ren", bus.l2_ren, 1);
        nrst         = 1'b0;
        bus.blk_req  = 1'b0;
        bus.l2_ready = 1'b0;
        @(negedge clk);
        exp_rdata = '0;
        check("mrst_done", bus.blk_done, 0);
        check("mrst_error", bus.blk_error, 0);
        check("mrst_rdata", bus.blk_rdata, 0);
        check("mrst_strobes", {bus.l2_ren, bus.l2_wen}, 0);
        check("mrst_addr", bus.l2_addr, 0);
        check("mrst_store", bus.l2_store, 0);
        nrst = 1'b1;
        @(negedge clk);
        check("mrst_nodone", bus.blk_done, 0);
        rand_plan(2);
        txn($urandom, 1'b0, {$urandom, $urandom}, 1'b0);

        // L2 never ready
        bus.blk_req  = 1'b1;
        bus.blk_wen  = 1'b0;
        bus.blk_addr = $urandom;
        bus.l2_ready = 1'b0;
        bus.l2_load  = $urandom;
        @(negedge clk);
        check("stall_ren", bus.l2_ren, 1);
        n_done = 0; done_at = -1; err_pulses = 0; err_at_done = 1'b0;
        for (int c = 0; c <= int'(Tmo) + 8; c++) begin
            if (bus.blk_error) err_pulses++;
            if (bus.blk_done) begin
                n_done++;
                done_at     = c;
                err_at_done = bus.blk_error;
                bus.blk_req = 1'b0;
            end
            @(negedge clk);
        end
`ifdef L2_ADAPTER_TIMEOUT_EN
        check("tmo_done_count", n_done, 1);
        check("tmo_done_cycle", done_at, Tmo + 1);
        check("tmo_error_at_done", err_at_done, 1);
        check("tmo_error_count", err_pulses, 1);
        check("tmo_rdata", bus.blk_rdata, exp_rdata);
`else
        check("stall_no_done", n_done, 0);
        check("stall_no_error", err_pulses, 0);
        bus.l2_ready = 1'b1;
        got_done = 1'b0;
        for (int c = 0; c < 10 && !got_done; c++) begin
            @(negedge clk);
            got_done = bus.blk_done;
        end
        exp_rdata = {bus.l2_load, bus.l2_load};
        check("stall_release_done", got_done, 1);
        check("stall_release_error", bus.blk_error, 0);
        check("stall_release_rdata", bus.blk_rdata, exp_rdata);
        bus.blk_req  = 1'b0;
        bus.l2_ready = 1'b0;
        @(negedge clk);
`endif

        rand_plan(3);
        txn($urandom, 1'b0, {$urandom, $urandom}, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
